// File: rtl/crp16_step_pkg.sv
// Shared definitions for the CRP16 CPU clock generator: state encoding,
// speed select codes and counter width.
package crp16_step_pkg;

  localparam int unsigned CNT_W = 28;

  // speed_sel codes, each selecting one of the DIVn half-periods
  localparam logic [1:0] SPEED_DIV0 = 2'd0;
  localparam logic [1:0] SPEED_DIV1 = 2'd1;
  localparam logic [1:0] SPEED_DIV2 = 2'd2;
  localparam logic [1:0] SPEED_DIV3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STEP_HIGH = 3'd1,
    STEP_LOW  = 3'd2,
    RUN_HIGH  = 3'd3,
    RUN_LOW   = 3'd4,
    HALT      = 3'd5
  } step_state_e;

  // States in which cpu_clock is high
  function automatic logic is_high_phase(input step_state_e s);
    return (s == STEP_HIGH) || (s == RUN_HIGH);
  endfunction

  // States timed by the divider
  function automatic logic is_timed_phase(input step_state_e s);
    return (s == STEP_HIGH) || (s == STEP_LOW) || (s == RUN_HIGH) || (s == RUN_LOW);
  endfunction

endpackage

// File: rtl/crp16_debounce.sv
// Push-button front end: 2-flop synchronizer, counter-based debouncer and a
// single-clock press event on each accepted release-to-press transition.
module crp16_debounce
  import crp16_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic step_key_n,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync_0;
  logic             sync_1;
  logic             key_db;
  logic [CNT_W-1:0] db_cnt;

  // Synchronize the raw button, converting to active-high
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
    end else begin
      sync_0 <= ~step_key_n;
      sync_1 <= sync_0;
    end
  end

  // Accept a new level only after it has persisted; any bounce restarts the count
  always_ff @(posedge clock) begin
    if (reset) begin
      key_db    <= 1'b0;
      db_cnt    <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (sync_1 != key_db) begin
        if (db_cnt == DB_LAST) begin
          key_db    <= sync_1;
          db_cnt    <= '0;
          press_evt <= sync_1;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/crp16_step_clock.sv
// CRP16 CPU clock generator: single-step on a debounced button or free-run at
// one of four rates, with a CPU cycle counter. Define CRP16_BREAKPOINT_EN to
// enable the PC breakpoint that halts free-run.
module crp16_step_clock
  import crp16_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DIV0            = 25000000,
  parameter int unsigned DIV1            = 2500000,
  parameter int unsigned DIV2            = 250000,
  parameter int unsigned DIV3            = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_key_n,
  input  logic        run_sw,
  input  logic [1:0]  speed_sel,
  input  logic [15:0] pc_addr,
  input  logic [15:0] bp_addr,
  input  logic        bp_en,
  output logic        cpu_clock,
  output logic        running,
  output logic        halted,
  output logic [15:0] cycle_count
);

  step_state_e      state;
  step_state_e      state_nxt;
  logic             press_evt;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] half_sel;
  logic             div_done;
  logic             enter_high;
  logic             bp_hit;
  logic             resume_q;
  logic [15:0]      count_q;

  crp16_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock     (clock),
    .reset     (reset),
    .step_key_n(step_key_n),
    .press_evt (press_evt)
  );

  // Half-period for a HIGH phase that starts this clock
  always_comb begin
    half_sel = CNT_W'(DIV0);
    case (speed_sel)
      SPEED_DIV0: half_sel = CNT_W'(DIV0);
      SPEED_DIV1: half_sel = CNT_W'(DIV1);
      SPEED_DIV2: half_sel = CNT_W'(DIV2);
      SPEED_DIV3: half_sel = CNT_W'(DIV3);
      default:    half_sel = CNT_W'(DIV0);
    endcase
  end

  assign div_done   = (div_cnt == half_q - CNT_W'(1));
  assign enter_high = is_high_phase(state_nxt) && !is_high_phase(state);

`ifdef CRP16_BREAKPOINT_EN
  logic bp_skip_q;
  logic halted_q;

  assign bp_hit = bp_en && (pc_addr == bp_addr) && !bp_skip_q;
  assign halted = halted_q;

  // Skip the first breakpoint check after leaving HALT; track HALT for the output
  always_ff @(posedge clock) begin
    if (reset) begin
      bp_skip_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      if (state == HALT && state_nxt != HALT) begin
        bp_skip_q <= 1'b1;
      end else if (state == RUN_LOW && div_done) begin
        bp_skip_q <= 1'b0;
      end
      halted_q <= (state_nxt == HALT);
    end
  end
`else
  logic unused_bp;

  assign unused_bp = ^{pc_addr, bp_addr, bp_en};
  assign bp_hit    = 1'b0;
  assign halted    = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; run_sw is only honoured at phase boundaries
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (run_sw)         state_nxt = RUN_HIGH;
        else if (press_evt) state_nxt = STEP_HIGH;
      end
      STEP_HIGH: begin
        if (div_done) state_nxt = STEP_LOW;
      end
      STEP_LOW: begin
        if (div_done) state_nxt = (resume_q && run_sw) ? RUN_HIGH : IDLE;
      end
      RUN_HIGH: begin
        if (div_done) state_nxt = RUN_LOW;
      end
      RUN_LOW: begin
        if (div_done) begin
          if (!run_sw)     state_nxt = IDLE;
          else if (bp_hit) state_nxt = HALT;
          else             state_nxt = RUN_HIGH;
        end
      end
      HALT: begin
        if (!run_sw)        state_nxt = IDLE;
        else if (press_evt) state_nxt = STEP_HIGH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase timer, rate latch, registered outputs and the CPU cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      half_q    <= '0;
      count_q   <= '0;
      cpu_clock <= 1'b0;
      running   <= 1'b0;
      resume_q  <= 1'b0;
    end else begin
      if (state_nxt != state || !is_timed_phase(state)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      if (enter_high) begin
        half_q <= half_sel;
      end
      count_q   <= count_q + 16'(enter_high);
      cpu_clock <= is_high_phase(state_nxt);
      running   <= (state_nxt == RUN_HIGH) || (state_nxt == RUN_LOW);
      if (state == HALT && state_nxt == STEP_HIGH) begin
        resume_q <= 1'b1;
      end else if (state == STEP_LOW && state_nxt != STEP_LOW) begin
        resume_q <= 1'b0;
      end
    end
  end

  assign cycle_count = count_q;

endmodule

// File: tb/tb_crp16_step_clock.sv
// Self-checking bench for crp16_step_clock with small divider values.
// Honours CRP16_BREAKPOINT_EN the same way the design does.
module tb_crp16_step_clock;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_key_n;
  logic        run_sw;
  logic [1:0]  speed_sel;
  logic [15:0] pc_addr;
  logic [15:0] bp_addr;
  logic        bp_en;
  logic        cpu_clock;
  logic        running;
  logic        halted;
  logic [15:0] cycle_count;

  always #5 clock = ~clock;

  crp16_step_clock #(
    .DEBOUNCE_CYCLES(4),
    .DIV0(8),
    .DIV1(4),
    .DIV2(2),
    .DIV3(1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .step_key_n (step_key_n),
    .run_sw     (run_sw),
    .speed_sel  (speed_sel),
    .pc_addr    (pc_addr),
    .bp_addr    (bp_addr),
    .bp_en      (bp_en),
    .cpu_clock  (cpu_clock),
    .running    (running),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;
  bit preload  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 single-step pulse, 2 free-run, 3 halted
  int          m_mode   = 0;
  bit          m_hi     = 1'b0;
  int          m_left   = 0;
  int          m_half   = 0;
  bit          m_resume = 1'b0;
  bit          m_skip   = 1'b0;
  logic [15:0] m_count  = '0;
  bit          k_s0 = 1'b0, k_s1 = 1'b0, k_db = 1'b0, k_press = 1'b0;
  int          k_cnt = 0;

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'd0:    return 8;
      2'd1:    return 4;
      2'd2:    return 2;
      default: return 1;
    endcase
  endfunction

  task automatic start_high(input int mode);
    m_mode  = mode;
    m_hi    = 1'b1;
    m_half  = div_of(speed_sel);
    m_left  = m_half;
    m_count = m_count + 16'd1;
  endtask

  always @(posedge clock) begin : model_blk
    bit press_now;
    bit bp;
    if (reset) begin
      m_mode = 0; m_hi = 1'b0; m_left = 0; m_resume = 1'b0; m_skip = 1'b0; m_count = '0;
      k_s0 = 1'b0; k_s1 = 1'b0; k_db = 1'b0; k_press = 1'b0; k_cnt = 0;
    end else begin
      press_now = k_press;
      bp = 1'b0;
`ifdef CRP16_BREAKPOINT_EN
      bp = bp_en && (pc_addr == bp_addr) && !m_skip;
`endif
      if (m_mode == 1 || m_mode == 2) begin
        m_left--;
        if (m_left == 0) begin
          if (m_hi) begin
            m_hi   = 1'b0;
            m_left = m_half;
          end else if (m_mode == 1) begin
            if (m_resume && run_sw) start_high(2);
            else m_mode = 0;
            m_resume = 1'b0;
          end else begin
            m_skip = 1'b0;
            if (!run_sw) m_mode = 0;
            else if (bp) m_mode = 3;
            else start_high(2);
          end
        end
      end else if (m_mode == 0) begin
        if (run_sw) start_high(2);
        else if (press_now) start_high(1);
      end else begin
        if (!run_sw) begin
          m_mode = 0; m_skip = 1'b1;
        end else if (press_now) begin
          start_high(1); m_resume = 1'b1; m_skip = 1'b1;
        end
      end
      if (preload) m_count = 16'hFFFE;
      k_press = 1'b0;
      if (k_s1 != k_db) begin
        k_cnt++;
        if (k_cnt == 4) begin
          k_db = k_s1; k_cnt = 0; k_press = k_db;
        end
      end else begin
        k_cnt = 0;
      end
      k_s1 = k_s0;
      k_s0 = !step_key_n;
    end
  end

  // ---------------- compare and pulse monitor ----------------
  int hi_cnt = 0, rise_cnt = 0, run_cnt = 0;
  bit prev_cpu = 1'b0;

  always @(negedge clock) begin
    if (check_en) begin
      check("cpu_clock", cpu_clock, m_hi);
      check("running", running, (m_mode == 2));
      check("halted", halted, (m_mode == 3));
      if (!preload) check("cycle_count", cycle_count, m_count);
    end
    if (cpu_clock === 1'b1) hi_cnt++;
    if (running === 1'b1) run_cnt++;
    if (cpu_clock === 1'b1 && !prev_cpu) rise_cnt++;
    prev_cpu = (cpu_clock === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #3;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int b_hi, b_rise, b_run, waited;
    reset = 1'b1; step_key_n = 1'b1; run_sw = 1'b0; speed_sel = 2'd0;
    pc_addr = '0; bp_addr = '0; bp_en = 1'b0;
    tick(2);
    check_en = 1'b1;
    check("rst_cpu_clock", cpu_clock, 16'd0);
    check("rst_cycle_count", cycle_count, 16'd0);
    check("rst_running", running, 16'd0);
    reset = 1'b0;
    tick(2);

    // single step at the slowest rate: one 8-clock high pulse
    b_hi = hi_cnt; b_rise = rise_cnt;
    step_key_n = 1'b0; tick(10);
    step_key_n = 1'b1; tick(30);
    check("step_high_len", 16'(hi_cnt - b_hi), 16'd8);
    check("step_pulses", 16'(rise_cnt - b_rise), 16'd1);
    check("step_count", cycle_count, 16'd1);
    check("step_running", running, 16'd0);

    // bouncing button produces nothing until it is held
    b_rise = rise_cnt;
    for (int i = 0; i < 10; i++) begin
      step_key_n = (i % 2 == 1);
      tick(2);
    end
    check("bounce_no_pulse", 16'(rise_cnt - b_rise), 16'd0);
    step_key_n = 1'b0;
    waited = 0;
    while (cpu_clock !== 1'b1 && waited < 20) begin
      tick(1);
      waited++;
    end
    check("bounce_press_latency", 16'(waited), 16'd7);
    tick(20);
    step_key_n = 1'b1;
    tick(10);
    check("bounce_one_pulse", 16'(rise_cnt - b_rise), 16'd1);
    check("bounce_count", cycle_count, 16'd2);

    // free-run at mixed rates; a press while running is discarded
    speed_sel = 2'd1; run_sw = 1'b1; tick(13);
    speed_sel = 2'd2; step_key_n = 1'b0; tick(15);
    step_key_n = 1'b1; speed_sel = 2'd3; tick(9);
    run_sw = 1'b0; tick(20);
    check("mixed_stop_running", running, 16'd0);
    check("mixed_stop_cpu", cpu_clock, 16'd0);

    // fastest free-run: period 2, 50 cycles in 100 clocks
    b_rise = rise_cnt; b_hi = hi_cnt;
    speed_sel = 2'd3; run_sw = 1'b1; tick(100);
    check("fast_rises", 16'(rise_cnt - b_rise), 16'd50);
    check("fast_high_clocks", 16'(hi_cnt - b_hi), 16'd50);
    run_sw = 1'b0; tick(4);

    // dropping run_sw mid-HIGH lets the whole period finish
    speed_sel = 2'd0;
    b_rise = rise_cnt; b_hi = hi_cnt; b_run = run_cnt;
    run_sw = 1'b1;
    waited = 0;
    while (cpu_clock !== 1'b1 && waited < 10) begin
      tick(1);
      waited++;
    end
    check("drop_run_started", cpu_clock, 16'd1);
    tick(3);
    run_sw = 1'b0;
    tick(30);
    check("drop_rises", 16'(rise_cnt - b_rise), 16'd1);
    check("drop_high_clocks", 16'(hi_cnt - b_hi), 16'd8);
    check("drop_running_clocks", 16'(run_cnt - b_run), 16'd16);
    check("drop_cpu_low", cpu_clock, 16'd0);
    check("drop_running", running, 16'd0);

    // reset in the middle of a HIGH phase
    run_sw = 1'b1;
    tick(3);
    reset = 1'b1; tick(1);
    check("midrst_cpu", cpu_clock, 16'd0);
    check("midrst_count", cycle_count, 16'd0);
    check("midrst_running", running, 16'd0);
    reset = 1'b0; tick(1);
    check("postrst_cpu", cpu_clock, 16'd1);
    check("postrst_running", running, 16'd1);
    check("postrst_count", cycle_count, 16'd1);
    run_sw = 1'b0; tick(20);

    // breakpoint
    bp_en = 1'b1; bp_addr = 16'h0005; pc_addr = 16'h0005; speed_sel = 2'd3;
    run_sw = 1'b1;
`ifdef CRP16_BREAKPOINT_EN
    waited = 0;
    while (halted !== 1'b1 && waited < 20) begin
      tick(1);
      waited++;
    end
    tick(3);
    check("bp_halted", halted, 16'd1);
    check("bp_cpu_held", cpu_clock, 16'd0);
    check("bp_running", running, 16'd0);
    b_rise = rise_cnt;
    step_key_n = 1'b0;
    waited = 0;
    while (running !== 1'b1 && waited < 30) begin
      tick(1);
      waited++;
    end
    step_key_n = 1'b1;
    tick(1);
    check("bp_resume_rises", 16'(rise_cnt - b_rise), 16'd2);
    tick(1);
    check("bp_no_rehalt", halted, 16'd0);
    check("bp_rerun_cpu", cpu_clock, 16'd1);
    pc_addr = 16'h0006;
    tick(10);
    check("bp_still_running", running, 16'd1);
    pc_addr = 16'h0005;
    tick(6);
    check("bp_rehalt", halted, 16'd1);
    run_sw = 1'b0;
    tick(2);
    check("bp_release_halted", halted, 16'd0);
    check("bp_release_running", running, 16'd0);
`else
    tick(20);
    check("nobp_halted", halted, 16'd0);
    check("nobp_running", running, 16'd1);
    run_sw = 1'b0;
    tick(4);
`endif
    bp_en = 1'b0;
    tick(10);

    // counter wrap from a preloaded value
    force dut.count_q = 16'hFFFE;
    preload = 1'b1;
    tick(1);
    release dut.count_q;
    preload = 1'b0;
    tick(1);
    check("wrap_preload", cycle_count, 16'hFFFE);
    speed_sel = 2'd3; run_sw = 1'b1;
    tick(1);
    check("wrap_ffff", cycle_count, 16'hFFFF);
    tick(2);
    check("wrap_zero", cycle_count, 16'h0000);
    tick(2);
    check("wrap_one", cycle_count, 16'h0001);
    run_sw = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crp16_step_clock.md
Name: crp16_step_clock

Overview:
- Generates the CPU clock (`cpu_clock`) that drives `crp16_datapath.clock` and, through it, `mem_clock`.
- Derives `cpu_clock` from the 50 MHz board clock, replacing the raw KEY[0] drive. Sits directly upstream of the datapath in `crp16_processor`.
- Two modes: debounced single-step on a push button, and free-run at one of four switch-selected rates.
- Counts CPU cycles; optional PC breakpoint halts free-run.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable board clocks needed to accept a button level change (10 ms).
- DIV0, 25000000, `cpu_clock` half-period in board clocks for speed_sel=0 (1 Hz).
- DIV1, 2500000, half-period for speed_sel=1 (10 Hz).
- DIV2, 250000, half-period for speed_sel=2 (100 Hz).
- DIV3, 2, half-period for speed_sel=3 (12.5 MHz).
- CNT_W, 28, width of the debounce and divider counters; must hold max(DEBOUNCE_CYCLES, DIV0..DIV3).

Ports:
- clock  in  1  50 MHz board clock; all logic is on its rising edge.
- reset  in  1  Synchronous, active-high; same signal as the datapath reset.
- step_key_n  in  1  Raw push button, active-low, asynchronous to clock.
- run_sw  in  1  1 = free-run, 0 = single-step.
- speed_sel  in  2  Selects DIV0..DIV3; sampled at the start of each HIGH phase.
- pc_addr  in  16  Datapath `address_a`; used by the breakpoint.
- bp_addr  in  16  Breakpoint address.
- bp_en  in  1  Breakpoint enable.
- cpu_clock  out  1  Registered clock for the datapath.
- running  out  1  1 while FSM is in RUN_HIGH or RUN_LOW.
- halted  out  1  1 while FSM is in HALT.
- cycle_count  out  16  Number of `cpu_clock` rising edges since reset; wraps.

Behaviour:
- Reset: synchronous, active-high. The next edge forces:
  - FSM = IDLE;
  - `cpu_clock`=0, `running`=0, `halted`=0, `cycle_count`=0;
  - divider and debounce counters = 0;
  - debounced key = released.
- Reset asserted mid-phase truncates the phase immediately; a `cpu_clock` high pulse may be shortened.
- Button input path:
  - `step_key_n` passes through a 2-flop synchronizer (inverted to active-high).
  - The debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive clocks. Any bounce restarts the count.
  - `press_evt` is a one-clock pulse on a debounced 0→1 transition.
  - Holding the button yields a single event.
- FSM states: IDLE, STEP_HIGH, STEP_LOW, RUN_HIGH, RUN_LOW, HALT.
- Every *_HIGH / *_LOW phase lasts exactly `half` board clocks. `half` = DIVn latched at phase-HIGH entry. The divider counter counts 0..half-1.
- `cpu_clock`=1 exactly while in a *_HIGH state (registered with the state, no glitches).
- Transitions:
  - IDLE: `run_sw`=1 → RUN_HIGH. Else `press_evt` → STEP_HIGH.
  - STEP_HIGH → STEP_LOW when the divider expires.
  - STEP_LOW → IDLE when the divider expires.
  - RUN_HIGH → RUN_LOW when the divider expires.
  - RUN_LOW when the divider expires:
    - `run_sw`=0 → IDLE;
    - breakpoint match → HALT;
    - otherwise → RUN_HIGH.
  - HALT:
    - `run_sw`=0 → IDLE, `halted` drops;
    - `press_evt` → STEP_HIGH with `resume` flag set. At the end of that STEP_LOW, FSM → RUN_HIGH if `run_sw`=1, else IDLE.
- `press_evt` outside IDLE and HALT is discarded, not queued.
- `run_sw` changes take effect only at phase boundaries. The current period always completes.
- `cycle_count` increments on every *_HIGH entry. It wraps 0xFFFF→0x0000.
- Speed change mid-period: the new rate applies from the next HIGH entry.

Optional Feature:
- Macro: CRP16_BREAKPOINT_EN.
- Defined:
  - Breakpoint match = `bp_en` && `pc_addr`==`bp_addr`, sampled on the last clock of RUN_LOW.
  - The match is suppressed for the first RUN_LOW after leaving HALT, so a stalled PC cannot re-halt.
- Undefined:
  - `pc_addr`, `bp_addr` and `bp_en` are unused.
  - HALT is unreachable and `halted` is tied 0.

Decomposition:
- Package `crp16_step_pkg` holds:
  - the FSM state encoding (3-bit enum);
  - the speed_sel→DIVn index constants;
  - CNT_W.
- One sub-module, `crp16_debounce`: synchronizer, debounce counter and `press_evt` edge detector (parameter DEBOUNCE_CYCLES).

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, DIV0=8, DIV1=4, DIV2=2, DIV3=1.
- Single step: `run_sw`=0, `step_key_n` low for 10 clocks → exactly one `cpu_clock` high of 8 clocks, then 8 low; `cycle_count`=1; FSM=IDLE.
- Bounce: `step_key_n` toggles every 2 clocks for 20 clocks, then held low → no pulse during bouncing; exactly one pulse after 4 stable clocks plus 2 synchronizer clocks.
- Free-run: `run_sw`=1, `speed_sel`=3 for 100 clocks → `cpu_clock` period 2, `cycle_count`=50±1. Dropping `run_sw` mid-HIGH → period completes, `cpu_clock` stays 0, `running`=0.
- Breakpoint (macro on): `bp_en`=1, `bp_addr`=0x0005, `pc_addr`=0x0005 during RUN_LOW → `halted`=1, `cpu_clock` held 0. Press → one pulse, then `running` resumes, no re-halt while `pc_addr` still 0x0005.
- Reset mid-RUN_HIGH → next clock `cpu_clock`=0, `cycle_count`=0, FSM=IDLE. With `run_sw`=1 the next clock enters RUN_HIGH.
- Wrap: preload by running 65536 periods at `speed_sel`=3 → `cycle_count` returns to 0x0000.
